// File: rtl/varredura_teclado4x4.sv
// varredura_teclado4x4: 4x4 matrix keypad scanner with frame-level debounce.
// Columns are driven one at a time (active low), the synchronized rows are
// folded into a 16-bit frame, and a frame is committed to `teclas` only after
// DEBOUNCE identical consecutive sweeps.
module varredura_teclado4x4 #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  linhas,
    output logic [3:0]  colunas,
    output logic [15:0] teclas,
    output logic        valido
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONFIRMA    = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    // Synchronizer and sweep registers
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [1:0]       col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      acc_q, acc_d;

    // Debounce registers
    estado_t          estado_q, estado_d;
    logic [15:0]      cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      teclas_q, teclas_d;
    logic             valido_q, valido_d;

    // Internal strobes
    logic             amostra;
    logic             frame_evt;
    logic [15:0]      frame;
    logic [CNT_W-1:0] cnt_inc;

    assign colunas = ~(4'b0001 << col_q);
    assign teclas  = teclas_q;
    assign valido  = valido_q;

    // Row synchronizer, column dwell counter and frame accumulation
    always_comb begin
        sync1_d   = linhas;
        sync2_d   = sync1_q;
        div_d     = div_q;
        col_d     = col_q;
        acc_d     = acc_q;
        amostra   = (div_q == DIV_W'(SCAN_DIV - 1));
        if (amostra) begin
            div_d = '0;
            col_d = col_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                acc_d[{2'(r), col_q}] = ~sync2_q[r];
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        // The column-3 sample closes a frame; the FSM sees it on the same edge.
        frame_evt = amostra && (col_q == 2'd3);
        frame     = acc_d;
    end

    // Debounce decision, evaluated only on frame events
    always_comb begin
        estado_d = estado_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        teclas_d = teclas_q;
        valido_d = 1'b0;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (frame_evt) begin
            unique case (estado_q)
                SOLTO: begin
                    if (frame != 16'h0000) begin
                        estado_d = CONFIRMA;
                        cand_d   = frame;
                        cnt_d    = CNT_W'(1);
                    end
                end
                CONFIRMA: begin
                    if (frame == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            estado_d = PRESSIONADO;
                            teclas_d = cand_q;
                            valido_d = 1'b1;
                        end
                    end else if (frame == 16'h0000) begin
                        estado_d = SOLTO;
                    end else begin
                        cand_d = frame;
                        cnt_d  = CNT_W'(1);
                    end
                end
                PRESSIONADO: begin
                    if (frame != teclas_q) begin
                        estado_d = SOLTANDO;
                        cand_d   = frame;
                        cnt_d    = CNT_W'(1);
                    end
                end
                SOLTANDO: begin
                    if (frame == teclas_q) begin
                        // Bounce back to the committed vector: no pulse.
                        estado_d = PRESSIONADO;
                    end else if (frame == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            if (cand_q == 16'h0000) begin
                                estado_d = SOLTO;
                                teclas_d = 16'h0000;
                            end else begin
                                estado_d = PRESSIONADO;
                                teclas_d = cand_q;
                                valido_d = 1'b1;
                            end
                        end
                    end else begin
                        cand_d = frame;
                        cnt_d  = CNT_W'(1);
                    end
                end
                default: estado_d = SOLTO;
            endcase
        end
    end

    // State registers with synchronous reset; synchronizer resets to "no key"
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            col_q    <= 2'd0;
            div_q    <= '0;
            acc_q    <= 16'h0000;
            estado_q <= SOLTO;
            cand_q   <= 16'h0000;
            cnt_q    <= '0;
            teclas_q <= 16'h0000;
            valido_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            col_q    <= col_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
            estado_q <= estado_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            teclas_q <= teclas_d;
            valido_q <= valido_d;
        end
    end

endmodule

// File: tb/tb_varredura_teclado4x4.sv
// Bench for varredura_teclado4x4: ideal keypad model, frame-level reference
// model feeding an expected queue, and a per-cycle monitor.
module tb_varredura_teclado4x4;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  linhas;
    logic [3:0]  colunas;
    logic [15:0] teclas;
    logic        valido;
    logic [15:0] pressed = 16'h0000;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [16:0] exp_q[$];      // {valido, teclas} expected at each frame boundary
    logic [15:0] hist[$];       // last DB frames seen by the reference model
    logic [15:0] teclas_m = 16'h0000;
    logic [15:0] hold_teclas = 16'h0000;

    varredura_teclado4x4 #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .linhas  (linhas),
        .colunas (colunas),
        .teclas  (teclas),
        .valido  (valido)
    );

    // Clock
    always #5 clk = ~clk;

    // Cycle index: 0 is the first cycle after the last reset edge
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Ideal keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        linhas = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (colunas[c] === 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[4*r+c]) linhas[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: commit a frame once the last DB frames all equal it
    task automatic model_step(input logic [15:0] f);
        logic v;
        bit   all_eq;
        hist.push_back(f);
        if (hist.size() > DB) void'(hist.pop_front());
        v = 1'b0;
        if (hist.size() == DB) begin
            all_eq = 1'b1;
            foreach (hist[i]) if (hist[i] != f) all_eq = 1'b0;
            if (all_eq && f != teclas_m) begin
                teclas_m = f;
                v = (f != 16'h0000);
            end
        end
        exp_q.push_back({v, teclas_m});
    endtask

    task automatic model_reset();
        hist.delete();
        teclas_m = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Hold a key set for one full sweep, starting at a frame boundary
    task automatic run_frame(input logic [15:0] keys);
        pressed = keys;
        model_step(keys);
        repeat (FRAME) tick();
    endtask

    // Monitor: column rotation every cycle, frame results at boundaries
    always @(negedge clk) begin
        logic [16:0] e;
        logic [3:0]  exp_col;
        exp_col = ~(4'b0001 << ((cyc / SD) % 4));
        check("colunas", 32'(colunas), 32'(exp_col));
        if (cyc == 0) begin
            hold_teclas = 16'h0000;
            check("reset_teclas", 32'(teclas), 32'h0);
            check("reset_valido", 32'(valido), 32'h0);
        end else if (cyc % FRAME == 0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_no_expectation cyc=%0d got teclas=%h valido=%b", cyc, teclas, valido);
            end else begin
                e = exp_q.pop_front();
                check("frame_teclas", 32'(teclas), 32'(e[15:0]));
                check("frame_valido", 32'(valido), 32'(e[16]));
                hold_teclas = e[15:0];
            end
        end else begin
            check("idle_valido", 32'(valido), 32'h0);
            check("idle_teclas", 32'(teclas), 32'(hold_teclas));
        end
    end

    // Stimulus
    initial begin
        logic [15:0] k;
        int          len;

        // Key 5 held from cycle 0: commit at cycle 48
        do_reset();
        repeat (4) run_frame(16'h0020);

        // Bounce: present, present, absent, then present -> commit at cycle 96
        do_reset();
        run_frame(16'h0020);
        run_frame(16'h0020);
        run_frame(16'h0000);
        repeat (4) run_frame(16'h0020);

        // Release after commit, then a single-zero-frame bounce
        do_reset();
        repeat (3) run_frame(16'h0020);
        repeat (3) run_frame(16'h0000);
        repeat (3) run_frame(16'h0020);
        run_frame(16'h0000);
        repeat (3) run_frame(16'h0020);

        // Key change 5 -> 10
        do_reset();
        repeat (3) run_frame(16'h0020);
        repeat (4) run_frame(16'h0400);

        // Multi-key pass-through
        do_reset();
        repeat (4) run_frame(16'h8421);

        // Reset at cycle 40 while key 5 is still debouncing
        do_reset();
        run_frame(16'h0020);
        run_frame(16'h0020);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        repeat (4) run_frame(16'h0020);

        // Random segments of held key sets
        do_reset();
        for (int s = 0; s < 45; s++) begin
            case ($urandom_range(0, 4))
                0:       k = 16'h0000;
                1:       k = 16'h0020;
                2:       k = 16'h0400;
                3:       k = 16'h0001 << $urandom_range(0, 15);
                default: k = 16'($urandom);
            endcase
            len = $urandom_range(1, 4);
            repeat (len) run_frame(k);
        end

        repeat (3) tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/varredura_teclado4x4.md
# varredura_teclado4x4

Scanner and debouncer for a 4x4 matrix keypad. It drives the keypad columns one at a time, reads the active-low row lines and assembles a 16-bit key frame. It only commits a frame after it has stayed unchanged for a configurable number of full sweeps. The committed one-hot/multi-hot vector `teclas` feeds the 16-to-4 binary encoder stage directly.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE`, default 3: number of consecutive identical frames required to commit. Must be ≥ 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `linhas`  in  4  keypad rows, active low, externally pulled up. `linhas[r]`=0 means a key in row r of the driven column is pressed.
- `colunas`  out  4  column drive, active-low one-hot. Exactly one bit is 0.
- `teclas`  out  16  committed key vector. Bit k=4·r+c is set when key (row r, column c) is pressed.
- `valido`  out  1  one-cycle pulse when a new nonzero vector is committed to `teclas`.

## Operation
- `linhas` passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- Column sweep:
  - Column index `col` (2 bits) and dwell counter `div` (0..SCAN_DIV-1).
  - `colunas` = ~(1<<col).
  - At `div`=SCAN_DIV-1: store bits [4r+col] ← ~linhas_sync[r] into the frame accumulator, then set `div`←0 and `col`←col+1. Col 3 wraps to 0.
- Frame event: the sample of column 3 completes a frame. That is a one-cycle internal strobe, with `frame` = accumulator including column 3.
- Debounce FSM. Registers: `cand` (16 bits) and `cnt` (counts frames up to DEBOUNCE). The FSM acts only on frame events.
  - SOLTO (`teclas`=0):
    - frame≠0 → CONFIRMA, with `cand`=frame and `cnt`=1.
  - CONFIRMA:
    - frame==cand → `cnt`++. When `cnt` reaches DEBOUNCE: go to PRESSIONADO, `teclas`←cand, `valido`=1.
    - frame==0 → SOLTO.
    - Any other frame → `cand`=frame, `cnt`=1.
  - PRESSIONADO:
    - frame≠teclas → SOLTANDO, with `cand`=frame and `cnt`=1.
    - Otherwise stay.
  - SOLTANDO:
    - frame==teclas → PRESSIONADO. This is a bounce: no pulse, `teclas` unchanged.
    - frame==cand → `cnt`++. When it reaches DEBOUNCE:
      - cand==0 → SOLTO, `teclas`←0, no pulse.
      - otherwise → PRESSIONADO, `teclas`←cand, `valido`=1.
    - Any other frame → `cand`=frame, `cnt`=1.
- Multiple simultaneous keys are passed through as a multi-hot vector. Priority selection belongs to the downstream encoder. Ghosting is not filtered.
- `teclas` changes only at commit points. It never reflects a partial frame.

## Timing
- Reset values: `colunas`=4'b1110, `teclas`=16'h0000, `valido`=0, state SOLTO, `col`=0, `div`=0, `cnt`=0, `cand`=0, accumulator=0, synchronizer=all ones (no key).
- Cycle 0 is the first cycle after `rst` is deasserted. Column c is driven during cycles 4·SCAN_DIV·n + c·SCAN_DIV … +SCAN_DIV-1.
- Frame event k (k≥1) is sampled at the edge ending cycle 4·SCAN_DIV·k−1. FSM outputs from that event are visible in cycle 4·SCAN_DIV·k.
- `valido` is high for exactly one cycle, the same cycle `teclas` takes the new value.
- Minimum press-to-commit latency is DEBOUNCE frames. With the defaults that is 48 cycles.
- Synchronizer settling: SCAN_DIV≥4 guarantees the sample reflects the currently driven column.
- `rst` mid-operation: on the next edge all registers take their reset values. The partial frame and any debounce count are discarded, and the sweep restarts at column 0.

## Test plan
- Reset: hold `rst` 3 cycles, then release → `colunas`=1110, `teclas`=0, `valido`=0. `colunas` rotates 1110→1101→1011→0111 with 4 cycles each and wraps.
- Key 5 (row1,col1) held from cycle 0 (defaults) → `teclas`=16'h0020 from cycle 48. `valido`=1 only in cycle 48. `teclas` stays 0 before cycle 48.
- Bounce: key 5 present in frames 1–2, absent in frame 3, present from frame 4 on → no commit before cycle 96. `teclas`=16'h0020 and `valido` pulse at cycle 96.
- Release: after the commit in scenario 2, release the key so frames 4–6 are 0 → `teclas`=0 from cycle 96. `valido` stays 0. A single zero frame followed by the key again → `teclas` unchanged, no pulse.
- Key change: key 5 committed, then key 10 (row2,col2) held instead → `teclas`=16'h0400 after 3 frames of key 10, with one `valido` pulse.
- Reset mid-debounce: key 5 held, `rst` asserted for 1 cycle at cycle 40 → outputs at reset values next cycle. Commit occurs 3 full frames after release (48 cycles after the new cycle 0), not earlier.
